// File: rtl/alu.sv
// Registered 64-bit add-with-carry / AND (optional XOR) unit with C/V/Z flags.
// Define ALU_XOR_EN to add the xor_en_i port and the A^B result term.
module alu (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] inA_i,
    input  logic [63:0] inB_i,
    input  logic        cflag_i,
    input  logic        sum_en_i,
    input  logic        and_en_i,
`ifdef ALU_XOR_EN
    input  logic        xor_en_i,
`endif
    output logic [63:0] out_o,
    output logic        cflag_o,
    output logic        vflag_o,
    output logic        zflag_o
);

    logic [64:0] sum;
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;

    always_comb begin
        sum = {1'b0, inA_i} + {1'b0, inB_i} + {64'd0, cflag_i};
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        // Wired-OR mux: several enables may be active at once.
        if (sum_en_i) begin
            res = res | sum[63:0];
            c   = sum[64];
            v   = (inA_i[63] == inB_i[63]) && (sum[63] != inA_i[63]);
        end
        if (and_en_i) begin
            res = res | (inA_i & inB_i);
        end
`ifdef ALU_XOR_EN
        if (xor_en_i) begin
            res = res | (inA_i ^ inB_i);
        end
`endif
        z = (res == 64'd0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_o   <= '0;
            cflag_o <= 1'b0;
            vflag_o <= 1'b0;
            zflag_o <= 1'b0;
        end else begin
            out_o   <= res;
            cflag_o <= c;
            vflag_o <= v;
            zflag_o <= z;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: walking-one sums, AND pass-through,
// reset, enable combinations and (with ALU_XOR_EN) the XOR term.
module tb_alu;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] inA_i;
    logic [63:0] inB_i;
    logic        cflag_i;
    logic        sum_en_i;
    logic        and_en_i;
`ifdef ALU_XOR_EN
    logic        xor_en_i;
`endif
    logic [63:0] out_o;
    logic        cflag_o;
    logic        vflag_o;
    logic        zflag_o;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inA_i    (inA_i),
        .inB_i    (inB_i),
        .cflag_i  (cflag_i),
        .sum_en_i (sum_en_i),
        .and_en_i (and_en_i),
`ifdef ALU_XOR_EN
        .xor_en_i (xor_en_i),
`endif
        .out_o    (out_o),
        .cflag_o  (cflag_o),
        .vflag_o  (vflag_o),
        .zflag_o  (zflag_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one operation, clock it in, and leave outputs settled for sampling.
    task automatic step(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic s_en,
                        input logic a_en, input logic x_en);
        inA_i    = a;
        inB_i    = b;
        cflag_i  = cin;
        sum_en_i = s_en;
        and_en_i = a_en;
`ifdef ALU_XOR_EN
        xor_en_i = x_en;
`else
        if (x_en) begin
            $display("note: xor_en requested without ALU_XOR_EN");
        end
`endif
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== 67'd0) begin
            errors++;
            $display("FAIL reset_init got out=%h c=%b v=%b z=%b want all 0",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_sum_walk(input logic cin);
        logic [63:0] a;
        logic [63:0] e_out;
        logic        e_c;
        logic        e_v;
        logic        e_z;
        for (int k = 0; k < 64; k++) begin
            a     = 64'd1 << k;
            e_out = (a << 1) | {63'd0, cin};
            e_c   = (k == 63);
            e_v   = (k >= 62);
            e_z   = (k == 63) && !cin;
            step(a, a, cin, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({out_o, cflag_o, vflag_o, zflag_o} !==
                {e_out, e_c, e_v, e_z}) begin
                errors++;
                $display("FAIL sum_walk cin=%0b k=%0d got %h %b%b%b want %h %b%b%b",
                         cin, k, out_o, cflag_o, vflag_o, zflag_o,
                         e_out, e_c, e_v, e_z);
            end
        end
    endtask

    task automatic test_and_pass;
        logic [63:0] b;
        for (int k = 0; k < 64; k++) begin
            b = 64'd1 << k;
            step(64'hFFFF_FFFF_FFFF_FFFF, b, k[0], 1'b0, 1'b1, 1'b0);
            checks++;
            if ({out_o, cflag_o, vflag_o, zflag_o} !== {b, 3'b000}) begin
                errors++;
                $display("FAIL and_pass k=%0d got %h %b%b%b want %h 000",
                         k, out_o, cflag_o, vflag_o, zflag_o, b);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(64'd3, 64'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== {64'd7, 3'b000}) begin
            errors++;
            $display("FAIL pre_reset got %h %b%b%b want 7 000",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
        reset_i = 1'b1;
        step(64'd9, 64'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== 67'd0) begin
            errors++;
            $display("FAIL mid_reset got %h %b%b%b want 0 000",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
        reset_i = 1'b0;
        step(64'd5, 64'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== {64'd11, 3'b000}) begin
            errors++;
            $display("FAIL post_reset got %h %b%b%b want b 000",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
    endtask

    task automatic test_enables;
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== {64'd0, 3'b001}) begin
            errors++;
            $display("FAIL no_enable got %h %b%b%b want 0 001",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
        step(64'h0F, 64'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== {64'h1F, 3'b000}) begin
            errors++;
            $display("FAIL dual_enable got %h %b%b%b want 1f 000",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
        step(64'hF0, 64'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== {64'd0, 3'b001}) begin
            errors++;
            $display("FAIL and_cin got %h %b%b%b want 0 001",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
        step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !==
            {64'h8000_0000_0000_0000, 3'b010}) begin
            errors++;
            $display("FAIL pos_ovf got %h %b%b%b want 8000000000000000 010",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
    endtask

`ifdef ALU_XOR_EN
    task automatic test_xor;
        step(64'hFF00, 64'h0FF0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== {64'hF0F0, 3'b000}) begin
            errors++;
            $display("FAIL xor_diff got %h %b%b%b want f0f0 000",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
        step(64'h1234, 64'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({out_o, cflag_o, vflag_o, zflag_o} !== {64'd0, 3'b001}) begin
            errors++;
            $display("FAIL xor_same got %h %b%b%b want 0 001",
                     out_o, cflag_o, vflag_o, zflag_o);
        end
    endtask
`endif

    initial begin
        reset_i = 1'b1;
        test_reset();
        test_sum_walk(1'b0);
        test_sum_walk(1'b1);
        test_and_pass();
        test_reset_mid();
        test_enables();
`ifdef ALU_XOR_EN
        test_xor();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
